// File: rtl/ct_load_sched.sv
// Load scheduler for the counter's parameter-load port: buffers values in a FIFO
// and issues them as single-cycle ld pulses separated by at least MIN_GAP idle cycles.
module ct_load_sched #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int MIN_GAP    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    flush,
   output logic                    ld,
   output logic [DATA_WIDTH-1:0]   data,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    busy,
   output logic [1:0]              fsm_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t                  state, state_next;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [GW-1:0]           gap_cnt, gap_cnt_next;
   logic                    push, pop;
   logic [LW-1:0]           level_next;

   // valid/ready: a value transfers on a posedge where in_valid && in_ready;
   // in_ready is a register, so a pop in the full cycle cannot admit a push.
   assign push       = in_valid && in_ready && !flush;
   assign pop        = (state == ISSUE);
   assign level_next = flush ? '0 : (level + LW'(push) - LW'(pop));
   assign fsm_state  = state;

   always_comb begin
      state_next   = state;
      gap_cnt_next = gap_cnt;
      case (state)
         IDLE: begin
            if ((level != '0) && !flush) state_next = ISSUE;
         end
         ISSUE: begin
            gap_cnt_next = '0;
            if (MIN_GAP > 0)            state_next = GAP;
            else if (level_next != '0)  state_next = ISSUE;
            else                        state_next = IDLE;
         end
         GAP: begin
            if (gap_cnt == GW'(MIN_GAP - 1))
               state_next = (level_next != '0) ? ISSUE : IDLE;
            else
               gap_cnt_next = gap_cnt + 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gap_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         in_ready <= 1'b0;
         ld       <= 1'b0;
         data     <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         gap_cnt  <= gap_cnt_next;
         level    <= level_next;
         in_ready <= (level_next != LW'(DEPTH));
         busy     <= (level_next != '0) || (state_next != IDLE);
         ld       <= pop;
         if (pop) data <= mem[rd_ptr];
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_ct_load_sched.sv
// Self-checking bench for ct_load_sched: vector table for reset/single load,
// hand sequences for burst/full, flush, reset mid-gap and a MIN_GAP=0 build.
module tb_ct_load_sched;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   // clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic          in_valid, in_ready, flush, ld, busy;
   logic [DW-1:0] in_data, data;
   logic [2:0]    level;
   logic [1:0]    fsm_state;

   logic          z_valid, z_ready, z_flush, z_ld, z_busy;
   logic [DW-1:0] z_in_data, z_data;
   logic [2:0]    z_level;
   logic [1:0]    z_state;

   ct_load_sched #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MIN_GAP(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .flush(flush), .ld(ld), .data(data),
      .level(level), .busy(busy), .fsm_state(fsm_state)
   );

   ct_load_sched #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MIN_GAP(0)) dut_z (
      .clk(clk), .rst(rst), .in_valid(z_valid), .in_ready(z_ready),
      .in_data(z_in_data), .flush(z_flush), .ld(z_ld), .data(z_data),
      .level(z_level), .busy(z_busy), .fsm_state(z_state)
   );

   // scoreboard
   int            errors = 0;
   int            checks = 0;
   int            cyc    = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   typedef struct {
      logic          rst;
      logic          vld;
      logic [DW-1:0] din;
      logic          e_ld;
      logic [DW-1:0] e_data;
      logic [2:0]    e_level;
      logic          e_rdy;
      logic          e_busy;
   } vec_t;

   vec_t vecs[10];

   int   sent, n_ld, last_ld, m_level, idx, first_ld, flush_pending;
   bit   saw_full, did_push;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
      z_valid = 1'b0; z_in_data = '0; z_flush = 1'b0;

      // reset for 3 cycles with in_valid high, then a single 0xA5 load
      vecs[0] = '{1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 3'd1, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'd1, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};

      for (int i = 0; i < 10; i++) begin
         rst = vecs[i].rst; in_valid = vecs[i].vld; in_data = vecs[i].din;
         step();
         check($sformatf("v%0d_ld", i), 32'(ld), 32'(vecs[i].e_ld));
         check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].e_data));
         check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_level));
         check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
         if (i == 0) check("reset_fsm_idle", 32'(fsm_state), 32'd0);
      end
      in_valid = 1'b0;

      // burst of 6 into a 4-deep FIFO: order, 3-cycle spacing, full back-pressure
      sent = 0; n_ld = 0; last_ld = -100; m_level = 0; saw_full = 1'b0;
      exp_q.delete();
      for (int k = 1; k <= 6; k++) exp_q.push_back(DW'(k));
      for (int c = 0; c < 40; c++) begin
         in_valid = (sent < 6);
         in_data  = DW'(sent + 1);
         did_push = in_valid && in_ready;
         step();
         if (did_push) begin
            sent++;
            m_level++;
         end
         if (ld) begin
            m_level--;
            n_ld++;
            if (exp_q.size() > 0) check("burst_data", 32'(data), 32'(exp_q.pop_front()));
            else check("burst_extra_ld", 32'(ld), 32'd0);
            if (n_ld > 1) check("burst_spacing", 32'(cyc - last_ld), 32'd3);
            last_ld = cyc;
         end
         check("burst_level", 32'(level), 32'(m_level));
         check("burst_in_ready", 32'(in_ready), 32'(m_level != DEPTH));
         if (m_level == DEPTH) saw_full = 1'b1;
      end
      in_valid = 1'b0;
      check("burst_ld_count", 32'(n_ld), 32'd6);
      check("burst_saw_full", 32'(saw_full), 32'd1);
      check("burst_queue_empty", 32'(exp_q.size()), 32'd0);

      // flush during the first ld: only 0x10 may be issued
      idx = 0; n_ld = 0; flush_pending = 0;
      for (int c = 0; c < 16; c++) begin
         in_valid = (idx < 4);
         in_data  = DW'(8'h10 + idx);
         flush    = (flush_pending == 1);
         did_push = in_valid && in_ready;
         step();
         if (did_push) idx++;
         if (flush) begin
            check("flush_level", 32'(level), 32'd0);
            flush_pending = 2;
         end
         if (ld) begin
            n_ld++;
            if (n_ld == 1) begin
               check("flush_first_data", 32'(data), 32'h10);
               flush_pending = 1;
            end
         end
      end
      flush = 1'b0; in_valid = 1'b0;
      check("flush_ld_count", 32'(n_ld), 32'd1);
      check("flush_data_hold", 32'(data), 32'h10);
      check("flush_level_end", 32'(level), 32'd0);
      check("flush_busy_end", 32'(busy), 32'd0);

      // reset during GAP with two entries still queued
      idx = 0; first_ld = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid = (idx < 3);
         in_data  = DW'(8'h31 + idx);
         did_push = in_valid && in_ready;
         step();
         if (did_push) idx++;
         if (ld) begin
            first_ld = 1;
            break;
         end
      end
      in_valid = 1'b0;
      check("gap_rst_saw_ld", 32'(first_ld), 32'd1);
      check("gap_rst_level_pre", 32'(level), 32'd2);
      rst = 1'b1;
      step();
      check("gap_rst_ld", 32'(ld), 32'd0);
      check("gap_rst_data", 32'(data), 32'd0);
      check("gap_rst_level", 32'(level), 32'd0);
      check("gap_rst_in_ready", 32'(in_ready), 32'd0);
      check("gap_rst_busy", 32'(busy), 32'd0);
      check("gap_rst_fsm", 32'(fsm_state), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         check("post_rst_ld", 32'(ld), 32'd0);
         check("post_rst_level", 32'(level), 32'd0);
         check("post_rst_in_ready", 32'(in_ready), 32'd1);
      end

      // MIN_GAP=0 build: four back-to-back values give four consecutive ld cycles
      idx = 0; n_ld = 0; first_ld = -1; last_ld = -1;
      exp_q.delete();
      for (int k = 1; k <= 4; k++) exp_q.push_back(DW'(k));
      for (int c = 0; c < 20; c++) begin
         z_valid   = (idx < 4);
         z_in_data = DW'(idx + 1);
         did_push  = z_valid && z_ready;
         step();
         if (did_push) idx++;
         if (z_ld) begin
            n_ld++;
            if (first_ld < 0) first_ld = cyc;
            last_ld = cyc;
            if (exp_q.size() > 0) check("gap0_data", 32'(z_data), 32'(exp_q.pop_front()));
            else check("gap0_extra_ld", 32'(z_ld), 32'd0);
         end
      end
      z_valid = 1'b0;
      check("gap0_ld_count", 32'(n_ld), 32'd4);
      check("gap0_consecutive", 32'(last_ld - first_ld), 32'd3);
      check("gap0_level_end", 32'(z_level), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
